refill_mem: RTL and testbench
=============================

REFILL_MEM -- requirements
Module: refill_mem

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-index width; the array holds 2^ADDR_W words of 32 bits.
REQ-002 SHALL provide parameter RD_LAT, default 3, the number of cycles from read acceptance to rd_valid; legal values are 1..15.
REQ-003 SHALL provide parameter WR_LAT, default 2, the number of cycles from write acceptance to array commit; legal values are 1..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_req  input  1  refill read request; held high until accepted.
REQ-007 rd_addr  input  32  byte address of the refill word.
REQ-008 rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-009 rd_data  output  32  refill data.
REQ-010 wr_req  input  1  dirty-writeback request; held high until wr_ack.
REQ-011 wr_addr  input  32  byte address of the writeback word.
REQ-012 wr_data  input  32  writeback data.
REQ-013 wr_ack  output  1  one-cycle pulse confirming write acceptance.
REQ-014 busy  output  1  high when a read is in flight or the write buffer is occupied.

Function
REQ-015 Word index SHALL be addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 SHALL be ignored.
REQ-016 The read FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-017 IDLE: when rd_req=1 and no read stall (REQ-024) applies, the block SHALL accept the read, snapshot the data, and go to WAIT with counter=RD_LAT-1, or go directly to RESP when RD_LAT=1.
REQ-018 WAIT: the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-019 RESP: rd_valid=1 for exactly one cycle with the snapshot on rd_data, then the FSM SHALL return to IDLE; rd_req SHALL be ignored outside IDLE.
REQ-020 Read latency: with acceptance at edge N, rd_valid SHALL be high in the cycle following edge N+RD_LAT.
REQ-021 The one-entry write buffer holds valid, index, data and a counter; wr_req with the buffer empty SHALL capture the entry, load counter=WR_LAT, and pulse wr_ack in the following cycle.
REQ-022 With the buffer full, wr_req SHALL NOT be acknowledged; the counter SHALL decrement each cycle, and at 0 the entry SHALL be written to the array and the buffer cleared; a new write MAY be accepted on the commit edge.
REQ-023 The read snapshot SHALL equal the memory contents at acceptance, including the buffered entry and any write accepted on the same edge; later writes SHALL NOT alter it.
REQ-024 Same-index hazard (buffer valid, or same-edge write, with a matching index) SHALL be resolved per REQ-030/REQ-031.
REQ-025 Simultaneous rd_req and wr_req to different indices SHALL both be accepted on the same edge.
REQ-026 rd_data SHALL hold its last value outside rd_valid cycles.

Reset
REQ-027 Reset SHALL force the read FSM to IDLE, clear the buffer valid bit and counters, and set rd_valid=0, wr_ack=0, busy=0, rd_data=0.
REQ-028 Reset asserted mid-operation SHALL abort the in-flight read (no rd_valid) and drop an uncommitted buffered write.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 With REFILL_MEM_FWD_EN defined, a same-index hazard read SHALL be accepted immediately and snapshot the buffer data.
REQ-031 Without REFILL_MEM_FWD_EN, a same-index hazard read SHALL stall in IDLE until the commit edge, then be accepted on the next edge and read the array.

Verification
REQ-032 Bench SHALL cover: reset, preload word 5=0xDEADBEEF, rd_req addr 0x14 at edge 0 -> rd_valid in the cycle after edge 3, rd_data=0xDEADBEEF.
REQ-033 Bench SHALL cover: wr_req addr 0x20 data 0x12345678 -> wr_ack pulse one cycle later; a read of 0x20 after busy=0 -> 0x12345678.
REQ-034 Bench SHALL cover: a write to 0x40 followed by rd_req 0x40 on the next edge -> with FWD_EN, data 0x40 returned after RD_LAT; without it, the read starts only after commit, same data.
REQ-035 Bench SHALL cover: two back-to-back held wr_req -> second wr_ack exactly WR_LAT+1 cycles after the first, both words committed.
REQ-036 Bench SHALL cover: reset asserted in WAIT -> no rd_valid, busy=0 immediately, and a preloaded word remains readable afterward.
REQ-037 Bench SHALL cover: same-edge rd_req 0x8 and wr_req 0xC -> both accepted, rd_valid after RD_LAT with the old word 2, and word 3 committed after WR_LAT.

Source files
------------

// File: rtl/refill_mem_if.sv
// Refill read / writeback port bundle between a cache and refill_mem.
interface refill_mem_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        busy;

  modport master (
    output rd_req, rd_addr,
    output wr_req, wr_addr, wr_data,
    input  rd_valid, rd_data,
    input  wr_ack, busy
  );

  modport slave (
    input  rd_req, rd_addr,
    input  wr_req, wr_addr, wr_data,
    output rd_valid, rd_data,
    output wr_ack, busy
  );
endinterface

// File: rtl/refill_mem.sv
// Refill memory: fixed-latency reads, one-entry posted write buffer.
// Define REFILL_MEM_FWD_EN to forward buffered data instead of stalling.
module refill_mem #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input logic         clk,
  input logic         reset,
  refill_mem_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_INIT = 4'(WR_LAT);

  logic [31:0] mem [2**ADDR_W];

  logic [1:0]  state;
  logic [3:0]  rd_cnt;
  logic [31:0] snap;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_idx;
  logic [31:0]       wb_data;
  logic [3:0]        wb_cnt;
  logic              wr_ack_q;

  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              commit;
  logic              wr_take;
  logic              rd_take;
  logic              rd_stall;
  logic [31:0]       rd_word;
  logic              unused_addr;

  assign rd_idx = bus.rd_addr[ADDR_W+1:2];
  assign wr_idx = bus.wr_addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                         bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

  // The buffer frees on its commit edge, so a new write can land there.
  assign commit  = wb_valid && (wb_cnt == 4'd0);
  assign wr_take = bus.wr_req && (!wb_valid || commit);

`ifdef REFILL_MEM_FWD_EN
  assign rd_stall = 1'b0;
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_take && wr_idx == rd_idx)
      rd_word = bus.wr_data;
    else if (wb_valid && wb_idx == rd_idx)
      rd_word = wb_data;
  end
`else
  assign rd_stall = (wb_valid && wb_idx == rd_idx)
                 || (wr_take && wr_idx == rd_idx);
  assign rd_word  = mem[rd_idx];
`endif

  assign rd_take = (state == IDLE) && bus.rd_req && !rd_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      snap       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_take) begin
            snap   <= rd_word;
            rd_cnt <= RD_INIT;
            state  <= (RD_LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          rd_cnt <= rd_cnt - 4'd1;
          if (rd_cnt == 4'd1)
            state <= RESP;
        end
        RESP: begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= snap;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
      wb_cnt   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_take;
      if (wr_take) begin
        wb_valid <= 1'b1;
        wb_idx   <= wr_idx;
        wb_data  <= bus.wr_data;
        wb_cnt   <= WR_INIT;
      end else if (commit) begin
        wb_valid <= 1'b0;
      end else if (wb_valid) begin
        wb_cnt <= wb_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit)
      mem[wb_idx] <= wb_data;
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.busy     = (state != IDLE) || wb_valid;
endmodule

// File: tb/tb_refill_mem.sv
// Directed and random bench for refill_mem against an edge-count model.
module tb_refill_mem;
  localparam int AW = 10;
  localparam int RL = 3;
  localparam int WL = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  refill_mem_if bus ();

  refill_mem #(.ADDR_W(AW), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  logic [31:0] mem_m [int];
  bit          m_pend;
  int          m_pi;
  logic [31:0] m_pd;
  int          m_pc;

  bit          rd_want;
  bit          rd_acc;
  logic [31:0] rd_a;
  int          rd_vedge;
  int          rd_free;
  logic [31:0] rd_snap;
  logic [31:0] rd_last;

  logic [31:0] wq_a [$];
  logic [31:0] wq_d [$];
  int          t_ack [$];
  int          t_rdv;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.rd_req  = rd_want || rd_acc;
    bus.rd_addr = rd_a;
    bus.wr_req  = wq_a.size() > 0;
    bus.wr_addr = (wq_a.size() > 0) ? wq_a[0] : 32'h0;
    bus.wr_data = (wq_d.size() > 0) ? wq_d[0] : 32'h0;
  endtask

  function automatic logic [31:0] rand_addr(int idx);
    logic [31:0] a;
    a = $urandom();
    a[AW+1:2] = AW'(idx);
    return a;
  endfunction

  task automatic rd(logic [31:0] a);
    rd_a = a;
    rd_want = 1'b1;
    drive();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    wq_a.push_back(a);
    wq_d.push_back(d);
    drive();
  endtask

  task automatic tick();
    int e, ri, wi;
    bit wacc, racc, hz, exp_v, exp_busy;
    @(posedge clk);
    edge_n++;
    e  = edge_n;
    ri = int'(rd_a[AW+1:2]);
    wi = (wq_a.size() > 0) ? int'(wq_a[0][AW+1:2]) : -1;
    wacc = (wq_a.size() > 0) && (!m_pend || m_pc <= e);
    hz = (m_pend && m_pc >= e && m_pi == ri) || (wacc && wi == ri);
`ifdef REFILL_MEM_FWD_EN
    hz = 1'b0;
`endif
    racc = rd_want && e >= rd_free && !hz;
    if (racc) begin
      if (wacc && wi == ri)         rd_snap = wq_d[0];
      else if (m_pend && m_pi == ri) rd_snap = m_pd;
      else                           rd_snap = mem_m[ri];
      rd_want  = 1'b0;
      rd_acc   = 1'b1;
      rd_vedge = e + RL;
      rd_free  = e + RL + 1;
    end
    if (m_pend && m_pc == e) begin
      mem_m[m_pi] = m_pd;
      m_pend = 1'b0;
    end
    if (wacc) begin
      m_pend = 1'b1;
      m_pi   = wi;
      m_pd   = wq_d[0];
      m_pc   = e + WL + 1;
      void'(wq_a.pop_front());
      void'(wq_d.pop_front());
    end
    #1;
    exp_v = rd_acc && e == rd_vedge;
    if (exp_v) rd_last = rd_snap;
    exp_busy = (rd_acc && e < rd_vedge) || m_pend;
    chk("wr_ack", 32'(bus.wr_ack), 32'(wacc));
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
    chk("rd_data", bus.rd_data, rd_last);
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    if (bus.wr_ack) t_ack.push_back(e);
    if (bus.rd_valid) t_rdv = e;
    if (exp_v) rd_acc = 1'b0;
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_want || rd_acc || wq_a.size() > 0 || m_pend) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset(bit immediate);
    reset = 1'b1;
    m_pend = 1'b0;
    rd_want = 1'b0;
    rd_acc = 1'b0;
    rd_free = 0;
    rd_last = '0;
    wq_a.delete();
    wq_d.delete();
    drive();
    #1;
    if (immediate) begin
      chk("rst_busy_now", 32'(bus.busy), 32'd0);
      chk("rst_rd_valid_now", 32'(bus.rd_valid), 32'd0);
      chk("rst_wr_ack_now", 32'(bus.wr_ack), 32'd0);
    end
    repeat (2) begin
      @(posedge clk);
      edge_n++;
      #1;
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rd_a = '0;
    t_rdv = -1;
    drive();
    do_reset(1'b0);

    // Preload word 5 and read it back with the nominal latency.
    wr(32'h14, 32'hDEADBEEF);
    drain();
    i = edge_n + 1;
    rd(32'h14);
    drain();
    chk("r_lat_word5", t_rdv, i + RL);
    chk("r_data_word5", bus.rd_data, 32'hDEADBEEF);

    t_ack.delete();
    i = edge_n + 1;
    wr(32'h20, 32'h12345678);
    drain();
    chk("w_ack_count", t_ack.size(), 1);
    if (t_ack.size() > 0) chk("w_ack_edge", t_ack[0], i);
    rd(32'h20);
    drain();
    chk("w_readback", bus.rd_data, 32'h12345678);

    // Read right behind a write to the same word.
    i = edge_n + 1;
    wr(32'h40, 32'h40);
    tick();
    rd(32'h40);
    drain();
`ifdef REFILL_MEM_FWD_EN
    chk("hazard_lat", t_rdv, i + 1 + RL);
`else
    chk("hazard_lat", t_rdv, i + WL + 2 + RL);
`endif
    chk("hazard_data", bus.rd_data, 32'h40);

    t_ack.delete();
    i = edge_n + 1;
    wr(32'h50, 32'hA5A5_0001);
    wr(32'h54, 32'h5A5A_0002);
    drain();
    chk("b2b_ack_count", t_ack.size(), 2);
    if (t_ack.size() == 2) begin
      chk("b2b_first", t_ack[0], i);
      chk("b2b_gap", t_ack[1] - t_ack[0], WL + 1);
    end
    rd(32'h50);
    drain();
    chk("b2b_word0", bus.rd_data, 32'hA5A5_0001);
    rd(32'h54);
    drain();
    chk("b2b_word1", bus.rd_data, 32'h5A5A_0002);

    // Abort a read in WAIT along with a buffered write.
    rd(32'h14);
    wr(32'h60, 32'h6666_6666);
    tick();
    do_reset(1'b1);
    rd(32'h14);
    drain();
    chk("post_reset_word5", bus.rd_data, 32'hDEADBEEF);

    wr(32'h8, 32'h2222_2222);
    wr(32'hC, 32'h3333_3333);
    drain();
    t_ack.delete();
    i = edge_n + 1;
    rd(32'h8);
    wr(32'hC, 32'hC0C0_C0C0);
    drain();
    chk("same_edge_ack_count", t_ack.size(), 1);
    if (t_ack.size() > 0) chk("same_edge_ack", t_ack[0], i);
    chk("same_edge_rd_lat", t_rdv, i + RL);
    chk("same_edge_old", bus.rd_data, 32'h2222_2222);
    rd(32'hC);
    drain();
    chk("same_edge_new", bus.rd_data, 32'hC0C0_C0C0);

    for (int k = 0; k < 400; k++) begin
      int idx;
      if (wq_a.size() < 2 && $urandom_range(0, 2) == 0)
        wr(rand_addr($urandom_range(0, 15)), $urandom());
      if (!rd_want && !rd_acc && $urandom_range(0, 1) == 0) begin
        idx = $urandom_range(0, 15);
        if (mem_m.exists(idx) || (m_pend && m_pi == idx))
          rd(rand_addr(idx));
      end
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
